hls_bus_mem_responder: RTL and testbench

- Memory-side consumer of the dBus command FIFOs written by the CPU-to-HLS bridge.
- Pops one command per transaction and services it against a single-port synchronous SRAM.
- Read responses, including multi-beat cache-line refills, go into the response FIFOs that the bridge drains back to the CPU.
- The block closes the FIFO loop in simulation and FPGA builds where no HLS kernel is attached.

---
 rtl/hls_bus_mem_responder_if.sv | 40 ++++
 rtl/hls_bus_mem_responder.sv | 145 ++++++++++++++
 tb/tb_hls_bus_mem_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_bus_mem_responder_if.sv
// Command FIFO, response FIFO and SRAM signals between the HLS bridge FIFOs and the memory responder.
interface hls_bus_mem_responder_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH  = 12
);
  logic                       cmd_empty_n;
  logic                       cmd_read;
  logic [DATA_ADDR_WIDTH-1:0] cmd_address_dout;
  logic [DATA_WIDTH-1:0]      cmd_data_dout;
  logic [3:0]                 cmd_mask_dout;
  logic                       cmd_write_dout;
  logic                       cmd_uncached_dout;
  logic [2:0]                 cmd_size_dout;
  logic                       cmd_last_dout;
  logic [DATA_WIDTH-1:0]      rsp_data_din;
  logic                       rsp_last_din;
  logic                       rsp_full_n;
  logic                       rsp_write;
  logic                       mem_en;
  logic                       mem_we;
  logic [MEM_ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [3:0]                 mem_wmask;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport slave (
    input  cmd_empty_n, cmd_address_dout, cmd_data_dout, cmd_mask_dout, cmd_write_dout,
           cmd_uncached_dout, cmd_size_dout, cmd_last_dout, rsp_full_n, mem_rdata,
    output cmd_read, rsp_data_din, rsp_last_din, rsp_write,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output cmd_empty_n, cmd_address_dout, cmd_data_dout, cmd_mask_dout, cmd_write_dout,
           cmd_uncached_dout, cmd_size_dout, cmd_last_dout, rsp_full_n, mem_rdata,
    input  cmd_read, rsp_data_din, rsp_last_din, rsp_write,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/hls_bus_mem_responder.sv
// Pops dBus commands, services them against a single-port SRAM and pushes read beats to the response FIFOs.
// state | meaning
// IDLE  | waiting for a command; pops and latches it
// WRITE | one-cycle masked SRAM write, no response
// READ  | issuing burst beats and draining them to the response FIFO
module hls_bus_mem_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  hls_bus_mem_responder_if.slave bus
);
  localparam int BPW      = DATA_WIDTH / 8;
  localparam int BPW_LOG2 = $clog2(BPW);
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state, state_nxt;

  logic [DATA_ADDR_WIDTH-1:0] cmd_addr;
  logic [MEM_ADDR_WIDTH-1:0]  cmd_waddr, cmd_base, cur_addr;
  logic [2:0]                 beats_log2;
  logic [CNT_W-1:0]           cmd_beats, beats_left;
  logic [DATA_WIDTH-1:0]      lat_data, pend_data, skid_data;
  logic [3:0]                 lat_mask;
  logic                       infl_valid, infl_last;
  logic                       pend_valid, pend_last, skid_valid, skid_last;
  logic [1:0]                 occ;
  logic                       pop, issue, push;
  logic                       unused_bits;

  assign cmd_addr    = bus.cmd_address_dout;
  assign unused_bits = ^{bus.cmd_uncached_dout, bus.cmd_last_dout, cmd_addr};

  // Bursts are aligned down to their own size, so beats never straddle a boundary.
  always_comb begin
    cmd_waddr  = cmd_addr[MEM_ADDR_WIDTH+BPW_LOG2-1:BPW_LOG2];
    beats_log2 = (bus.cmd_size_dout > 3'(BPW_LOG2)) ? bus.cmd_size_dout - 3'(BPW_LOG2) : 3'd0;
    cmd_beats  = CNT_W'(1) << beats_log2;
    cmd_base   = cmd_waddr & ~(MEM_ADDR_WIDTH'(cmd_beats - CNT_W'(1)));
  end

  // One beat may be in flight in the SRAM while the pending register waits on backpressure;
  // the skid register absorbs that beat so nothing is lost.
  assign occ = 2'(infl_valid) + 2'(pend_valid) + 2'(skid_valid);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    issue         = 1'b0;
    push          = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = cur_addr;
    bus.mem_wdata = lat_data;
    bus.mem_wmask = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_empty_n) begin
            pop       = 1'b1;
            state_nxt = bus.cmd_write_dout ? WRITE : READ;
          end
        end
        WRITE: begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_wmask = lat_mask;
          state_nxt     = IDLE;
        end
        READ: begin
          push       = pend_valid && bus.rsp_full_n;
          issue      = bus.rsp_full_n && (beats_left != '0) && ((occ < 2'd2) || push);
          bus.mem_en = issue;
          if (push && pend_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.cmd_read     = pop;
  assign bus.rsp_write    = push;
  assign bus.rsp_data_din = pend_data;
  assign bus.rsp_last_din = pend_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      lat_data   <= '0;
      lat_mask   <= '0;
      beats_left <= '0;
      infl_valid <= 1'b0;
      infl_last  <= 1'b0;
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
      pend_data  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (pop) begin
        cur_addr   <= bus.cmd_write_dout ? cmd_waddr : cmd_base;
        lat_data   <= bus.cmd_data_dout;
        lat_mask   <= bus.cmd_mask_dout;
        beats_left <= bus.cmd_write_dout ? '0 : cmd_beats;
      end else if (issue) begin
        cur_addr   <= cur_addr + 1'b1;
        beats_left <= beats_left - 1'b1;
      end
      infl_valid <= issue;
      infl_last  <= issue && (beats_left == CNT_W'(1));
      if (push) begin
        if (skid_valid) begin
          pend_data  <= skid_data;
          pend_last  <= skid_last;
          skid_valid <= infl_valid;
          skid_data  <= bus.mem_rdata;
          skid_last  <= infl_last;
        end else begin
          pend_valid <= infl_valid;
          pend_data  <= bus.mem_rdata;
          pend_last  <= infl_last;
        end
      end else if (infl_valid) begin
        if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend_data  <= bus.mem_rdata;
          pend_last  <= infl_last;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= bus.mem_rdata;
          skid_last  <= infl_last;
        end
      end
    end
  end
endmodule

// File: tb/tb_hls_bus_mem_responder.sv
// Scoreboard bench: command FIFO, SRAM and response FIFO models around the responder.
module tb_hls_bus_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hls_bus_mem_responder_if bus ();
  hls_bus_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] mask; logic write; logic [2:0] size;} cmd_t;
  typedef struct packed {logic [31:0] data; logic last;} rsp_t;
  typedef struct packed {logic [11:0] addr; logic [31:0] data; logic [3:0] mask;} wr_t;

  cmd_t cmdq[$];
  rsp_t expq[$];
  wr_t  wrq[$];
  logic [31:0] sram [4096];
  logic [31:0] model_mem [4096];

  int total = 0, bad = 0, cyc = 0, rsp_cnt = 0;
  int beat_idx = 0, first_cyc = 0, last_cyc = 0;
  int full_mode = 0, stall = 0;
  logic [31:0] last_rsp_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-merged writes, reads computed from the aligned burst rule.
  task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    int w;
    wr_t e;
    cmd_t c;
    w = int'(addr >> 2) % 4096;
    for (int b = 0; b < 4; b++)
      if (mask[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
    e.addr = 12'(w); e.data = data; e.mask = mask;
    wrq.push_back(e);
    c.addr = addr; c.data = data; c.mask = mask; c.write = 1'b1; c.size = 3'd2;
    cmdq.push_back(c);
  endtask

  task automatic push_read(input logic [31:0] addr, input logic [2:0] size);
    int w, nb, base;
    rsp_t e;
    cmd_t c;
    w  = int'(addr >> 2) % 4096;
    nb = (1 << size) / 4;
    if (nb < 1) nb = 1;
    base = (w / nb) * nb;
    for (int i = 0; i < nb; i++) begin
      e.data = model_mem[(base + i) % 4096];
      e.last = (i == nb - 1);
      expq.push_back(e);
    end
    c.addr = addr; c.data = $urandom(); c.mask = 4'($urandom()); c.write = 1'b0; c.size = size;
    cmdq.push_back(c);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Command FIFO and response-FIFO space driver.
  initial begin
    bit take;
    bus.cmd_empty_n = 1'b0; bus.cmd_address_dout = '0; bus.cmd_data_dout = '0; bus.cmd_mask_dout = '0;
    bus.cmd_write_dout = 1'b0; bus.cmd_uncached_dout = 1'b0; bus.cmd_size_dout = '0; bus.cmd_last_dout = 1'b0;
    bus.rsp_full_n = 1'b1;
    forever begin
      @(negedge clk);
      take = bus.cmd_read;
      @(posedge clk);
      #1;
      if (take) begin
        if (cmdq.size() == 0) check("cmd_read_while_empty", 64'd1, 64'd0);
        else void'(cmdq.pop_front());
      end
      if (cmdq.size() != 0) begin
        bus.cmd_empty_n = 1'b1;
        bus.cmd_address_dout = cmdq[0].addr; bus.cmd_data_dout = cmdq[0].data;
        bus.cmd_mask_dout = cmdq[0].mask; bus.cmd_write_dout = cmdq[0].write;
        bus.cmd_size_dout = cmdq[0].size; bus.cmd_uncached_dout = 1'($urandom());
        bus.cmd_last_dout = 1'($urandom());
      end else bus.cmd_empty_n = 1'b0;
      if (stall > 0) begin
        bus.rsp_full_n = 1'b0;
        stall--;
      end else if (full_mode == 1) bus.rsp_full_n = ((cyc % 2) == 1);
      else if (full_mode == 2) bus.rsp_full_n = ($urandom_range(0, 3) != 0);
      else bus.rsp_full_n = 1'b1;
    end
  end

  // Synchronous SRAM with one-cycle read latency; also checks every write against the model.
  initial begin
    bit en, we;
    logic [11:0] a;
    logic [31:0] wd;
    logic [3:0] m;
    wr_t e;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      en = bus.mem_en; we = bus.mem_we; a = bus.mem_addr; wd = bus.mem_wdata; m = bus.mem_wmask;
      @(posedge clk);
      #1;
      if (en && we) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) sram[a][8*b +: 8] = wd[8*b +: 8];
        if (wrq.size() == 0) check("mem_write_unexpected", 64'd1, 64'd0);
        else begin
          e = wrq.pop_front();
          check("mem_write", {a, wd, m}, {e.addr, e.data, e.mask});
        end
      end else if (en) bus.mem_rdata = sram[a];
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_write === 1'b1) begin
        rsp_cnt++;
        last_rsp_data = bus.rsp_data_din;
        if (beat_idx == 0) first_cyc = cyc;
        beat_idx++;
        if (bus.rsp_last_din) last_cyc = cyc;
        if (expq.size() == 0) check("rsp_unexpected", {bus.rsp_data_din, bus.rsp_last_din}, 64'd0);
        else begin
          e = expq.pop_front();
          check("rsp_beat", {bus.rsp_data_din, bus.rsp_last_din}, {e.data, e.last});
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((cmdq.size() != 0 || expq.size() != 0 || wrq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(name, 64'(n >= budget), 64'd0);
  endtask

  task automatic wait_beats(input string name, input int count);
    int n = 0;
    while (beat_idx < count && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n >= 300), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] hold_data;
    logic hold_last;
    for (int i = 0; i < 4096; i++) begin
      sram[i] = $urandom();
      model_mem[i] = sram[i];
    end

    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_quiet", {bus.cmd_read, bus.rsp_write, bus.mem_en, bus.mem_we}, 64'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_quiet", {bus.cmd_read, bus.rsp_write, bus.mem_en, bus.mem_we}, 64'd0);
    end

    base = rsp_cnt;
    push_write(32'h10, 32'hDEADBEEF, 4'hF);
    push_read(32'h10, 3'd2);
    drain("drain_wr_rd", 200);
    check("wr_rd_count", 64'(rsp_cnt - base), 64'd1);
    check("wr_rd_data", last_rsp_data, 64'hDEADBEEF);

    sram[4] = 32'h11223344;
    model_mem[4] = 32'h11223344;
    push_write(32'h10, 32'hAABBCCDD, 4'h3);
    push_read(32'h10, 3'd2);
    drain("drain_partial", 200);
    check("partial_data", last_rsp_data, 64'h1122CCDD);

    for (int i = 8; i < 16; i++) begin
      sram[i] = 32'h100 + 32'(i - 8);
      model_mem[i] = sram[i];
    end
    beat_idx = 0;
    push_read(32'h2C, 3'd5);
    drain("drain_refill", 200);
    check("refill_beats", 64'(beat_idx), 64'd8);
    check("refill_back_to_back", 64'(last_cyc - first_cyc), 64'd7);

    full_mode = 1;
    beat_idx = 0;
    push_read(32'h2C, 3'd5);
    wait_beats("bp_reach_beat3", 3);
    stall = 5;
    hold_data = '0; hold_last = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) begin
        hold_data = bus.rsp_data_din;
        hold_last = bus.rsp_last_din;
      end else if (k > 2) begin
        check("stall_hold", {bus.rsp_data_din, bus.rsp_last_din, bus.rsp_write}, {hold_data, hold_last, 1'b0});
      end
    end
    drain("drain_backpressure", 300);
    check("bp_beats", 64'(beat_idx), 64'd8);
    full_mode = 0;

    full_mode = 2;
    for (int n = 0; n < 60; n++) begin
      int w;
      logic [31:0] addr;
      w = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) w = (4096 - 32 + w) % 4096;
      addr = ($urandom() & 32'hFFFF_C000) | 32'(w << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) push_write(addr, $urandom(), 4'($urandom()));
      else push_read(addr, 3'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
    end
    drain("drain_random", 6000);
    full_mode = 0;

    beat_idx = 0;
    push_read(32'h2C, 3'd5);
    wait_beats("rst_reach_beat3", 3);
    @(posedge clk);
    #1 rst = 1'b1;
    expq.delete();
    cmdq.delete();
    base = rsp_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_no_more_rsp", 64'(rsp_cnt - base), 64'd0);
    push_read(32'h10, 3'd2);
    drain("drain_after_rst", 200);
    check("after_rst_count", 64'(rsp_cnt - base), 64'd1);
    check("after_rst_data", last_rsp_data, model_mem[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
